alu_core: RTL and testbench

- 6502 ALU core for the CPU datapath.
- Sits directly downstream of the A and B input registers and consumes their held operands (b_IN is driven by the B input register's b_REG_OUT).
- Computes SUM/AND/OR/EOR/SR and captures the result in the adder hold register, with carry, overflow and half-carry flags.
- Optional decimal-adjust second stage (BCD) for NMOS-compatible builds; disabled for 2A03.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_decimal_adjust.sv | 40 ++++
 rtl/alu_core.sv | 137 +++++++++++++
 tb/tb_alu_core.sv | 136 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the 6502 ALU core and its decimal-adjust stage.
package alu_pkg;

  typedef enum logic [2:0] {
    SUM = 3'd0,
    AND = 3'd1,
    OR  = 3'd2,
    EOR = 3'd3,
    SR  = 3'd4
  } alu_op_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ADJUST = 1'b1
  } alu_state_t;

  localparam logic [7:0] BCD_LOW_FIX  = 8'h06;
  localparam logic [7:0] BCD_HIGH_FIX = 8'h60;

  function automatic logic nibble_gt9(input logic [3:0] n);
    return n > 4'd9;
  endfunction

endpackage

// File: rtl/alu_decimal_adjust.sv
// Combinational BCD correction applied to a binary ALU sum (DAA for add, DSA for subtract).
module alu_decimal_adjust
  import alu_pkg::*;
(
  input  logic [7:0] bin,
  input  logic       carry,
  input  logic       half_carry,
  input  logic       sub,
  output logic [7:0] result,
  output logic       carry_adj
);

  logic [7:0] lo_res;
  logic       lo_fix;
  logic       hi_fix;

  always_comb begin
    lo_res    = bin;
    lo_fix    = 1'b0;
    hi_fix    = 1'b0;
    result    = bin;
    carry_adj = carry;
    if (sub) begin
      // Borrow-not flags: a missing carry means the nibble borrowed and needs -6.
      lo_fix    = ~half_carry;
      hi_fix    = ~carry;
      lo_res    = lo_fix ? bin - BCD_LOW_FIX : bin;
      result    = hi_fix ? lo_res - BCD_HIGH_FIX : lo_res;
      carry_adj = carry;
    end else begin
      // High-nibble test looks at the value after the low correction has rippled in.
      lo_fix    = half_carry | nibble_gt9(bin[3:0]);
      lo_res    = lo_fix ? bin + BCD_LOW_FIX : bin;
      hi_fix    = carry | nibble_gt9(lo_res[7:4]);
      result    = hi_fix ? lo_res + BCD_HIGH_FIX : lo_res;
      carry_adj = hi_fix;
    end
  end

endmodule

// File: rtl/alu_core.sv
// 6502 ALU core: binary SUM/AND/OR/EOR/SR into the adder hold register, with an
// optional one-cycle BCD adjust stage for NMOS-compatible builds.
module alu_core
  import alu_pkg::*;
#(
  parameter int DECIMAL_SUPPORT = 1,
  parameter int WIDTH           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_IN,
  input  logic [WIDTH-1:0] b_IN,
  input  logic             carry_IN,
  input  logic [2:0]       op_IN,
  input  logic             decimal_EN,
  input  logic             decimalSub_EN,
  input  logic             start_EN,
  output logic [WIDTH-1:0] hold_OUT,
  output logic             carry_OUT,
  output logic             overflow_OUT,
  output logic             halfCarry_OUT,
  output logic             valid_OUT,
  output logic             busy_OUT
);

  alu_state_t       state;
  logic [WIDTH-1:0] hold;
  logic             carry_q;
  logic             ovf_q;
  logic             half_q;
  logic             sub_q;
  logic             valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] bin_res;
  logic             bin_c;
  logic             bin_v;
  logic             bin_h;
  logic [WIDTH:0]   sum_full;
  logic [4:0]       sum_low;
  logic             go_adjust;

  logic [WIDTH-1:0] adj_res;
  logic             adj_c;

  assign sum_full = {1'b0, a_IN} + {1'b0, b_IN} + {{WIDTH{1'b0}}, carry_IN};
  assign sum_low  = {1'b0, a_IN[3:0]} + {1'b0, b_IN[3:0]} + {4'b0000, carry_IN};

  always_comb begin
    bin_res = '0;
    bin_c   = 1'b0;
    bin_v   = 1'b0;
    bin_h   = 1'b0;
    case (alu_op_t'(op_IN))
      SUM: begin
        bin_res = sum_full[WIDTH-1:0];
        bin_c   = sum_full[WIDTH];
        bin_h   = sum_low[4];
        bin_v   = ~(a_IN[WIDTH-1] ^ b_IN[WIDTH-1]) & (a_IN[WIDTH-1] ^ sum_full[WIDTH-1]);
      end
      AND: bin_res = a_IN & b_IN;
      OR:  bin_res = a_IN | b_IN;
      EOR: bin_res = a_IN ^ b_IN;
      SR: begin
        bin_res = {carry_IN, a_IN[WIDTH-1:1]};
        bin_c   = a_IN[0];
      end
      default: ;
    endcase
  end

  assign go_adjust = (DECIMAL_SUPPORT != 0) && (op_IN == SUM) && decimal_EN;

  generate
    if (DECIMAL_SUPPORT != 0) begin : g_dec
      alu_decimal_adjust u_adj (
        .bin        (hold),
        .carry      (carry_q),
        .half_carry (half_q),
        .sub        (sub_q),
        .result     (adj_res),
        .carry_adj  (adj_c)
      );
    end else begin : g_nodec
      // ADJUST is unreachable here; pass the hold register through unchanged.
      logic unused_sub;
      assign unused_sub = sub_q;
      assign adj_res    = hold;
      assign adj_c      = carry_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hold    <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      half_q  <= 1'b0;
      sub_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state == IDLE) begin
        if (start_EN) begin
          hold    <= bin_res;
          carry_q <= bin_c;
          ovf_q   <= bin_v;
          half_q  <= bin_h;
          sub_q   <= decimalSub_EN;
          if (go_adjust) begin
            state  <= ADJUST;
            busy_q <= 1'b1;
          end else begin
            valid_q <= 1'b1;
          end
        end
      end else begin
        // Overflow and half-carry keep their binary values through the adjust.
        hold    <= adj_res;
        carry_q <= adj_c;
        valid_q <= 1'b1;
        busy_q  <= 1'b0;
        state   <= IDLE;
      end
    end
  end

  assign hold_OUT      = hold;
  assign carry_OUT     = carry_q;
  assign overflow_OUT  = ovf_q;
  assign halfCarry_OUT = half_q;
  assign valid_OUT     = valid_q;
  assign busy_OUT      = busy_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: decimal-capable and binary-only builds side by side.
module tb_alu_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       cin = 1'b0;
  logic [2:0] op = 3'd0;
  logic       dec = 1'b0;
  logic       sub = 1'b0;
  logic       start = 1'b0;

  logic [7:0] d_hold, n_hold;
  logic       d_c, d_v, d_h, d_valid, d_busy;
  logic       n_c, n_v, n_h, n_valid, n_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_core #(.DECIMAL_SUPPORT(1), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .a_IN(a), .b_IN(b), .carry_IN(cin), .op_IN(op),
    .decimal_EN(dec), .decimalSub_EN(sub), .start_EN(start),
    .hold_OUT(d_hold), .carry_OUT(d_c), .overflow_OUT(d_v), .halfCarry_OUT(d_h),
    .valid_OUT(d_valid), .busy_OUT(d_busy)
  );

  alu_core #(.DECIMAL_SUPPORT(0), .WIDTH(8)) dut_bin (
    .clk(clk), .rst_n(rst_n), .a_IN(a), .b_IN(b), .carry_IN(cin), .op_IN(op),
    .decimal_EN(dec), .decimalSub_EN(sub), .start_EN(start),
    .hold_OUT(n_hold), .carry_OUT(n_c), .overflow_OUT(n_v), .halfCarry_OUT(n_h),
    .valid_OUT(n_valid), .busy_OUT(n_busy)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    logic       cin, dec, sub;
    logic [7:0] bin_r;
    logic       bin_c, bin_v, bin_h;
    logic [7:0] fin_r;
    logic       fin_c;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int i);
    a = v.a; b = v.b; cin = v.cin; op = v.op; dec = v.dec; sub = v.sub;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("bin_valid", i, {7'd0, n_valid}, 8'd1);
    chk("bin_hold",  i, n_hold, v.bin_r);
    chk("bin_flags", i, {5'd0, n_c, n_v, n_h}, {5'd0, v.bin_c, v.bin_v, v.bin_h});
    if (v.dec && v.op == 3'd0) begin
      chk("c1_busy_valid", i, {6'd0, d_busy, d_valid}, 8'b10);
      chk("c1_hold",       i, d_hold, v.bin_r);
      @(posedge clk); #1;
    end
    chk("busy_valid", i, {6'd0, d_busy, d_valid}, 8'b01);
    chk("hold",       i, d_hold, v.fin_r);
    chk("flags",      i, {5'd0, d_c, d_v, d_h}, {5'd0, v.fin_c, v.bin_v, v.bin_h});
    @(posedge clk); #1;
    chk("idle_valid", i, {6'd0, d_valid, n_valid}, 8'd0);
    chk("idle_hold",  i, d_hold, v.fin_r);
  endtask

  initial begin
    //          op    a      b      cin  dec  sub  bin_r  c  v  h  fin_r  fc
    vecs[0]  = '{3'd0, 8'h50, 8'h50, 0, 0, 0, 8'hA0, 0, 1, 0, 8'hA0, 0};
    vecs[1]  = '{3'd0, 8'hFF, 8'h01, 0, 0, 0, 8'h00, 1, 0, 1, 8'h00, 1};
    vecs[2]  = '{3'd4, 8'h81, 8'h55, 1, 0, 0, 8'hC0, 1, 0, 0, 8'hC0, 1};
    vecs[3]  = '{3'd3, 8'hF0, 8'h3C, 0, 0, 0, 8'hCC, 0, 0, 0, 8'hCC, 0};
    vecs[4]  = '{3'd1, 8'hF0, 8'h3C, 1, 0, 0, 8'h30, 0, 0, 0, 8'h30, 0};
    vecs[5]  = '{3'd2, 8'hF0, 8'h3C, 0, 0, 0, 8'hFC, 0, 0, 0, 8'hFC, 0};
    vecs[6]  = '{3'd5, 8'hFF, 8'hFF, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0};
    vecs[7]  = '{3'd0, 8'h7F, 8'h01, 0, 0, 0, 8'h80, 0, 1, 1, 8'h80, 0};
    vecs[8]  = '{3'd1, 8'h19, 8'h28, 0, 1, 0, 8'h08, 0, 0, 0, 8'h08, 0};
    vecs[9]  = '{3'd0, 8'h19, 8'h28, 0, 1, 0, 8'h41, 0, 0, 1, 8'h47, 0};
    vecs[10] = '{3'd0, 8'h99, 8'h01, 0, 1, 0, 8'h9A, 0, 0, 0, 8'h00, 1};
    vecs[11] = '{3'd0, 8'h58, 8'h46, 1, 1, 0, 8'h9F, 0, 1, 0, 8'h05, 1};
    vecs[12] = '{3'd0, 8'h00, 8'hFE, 1, 1, 1, 8'hFF, 0, 0, 0, 8'h99, 0};

    #12;
    chk("rst_hold",  0, d_hold, 8'h00);
    chk("rst_flags", 0, {3'd0, d_c, d_v, d_h, d_valid, d_busy}, 8'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_idle", 0, {6'd0, d_valid, d_busy}, 8'd0);

    for (int i = 0; i < 13; i++) apply(vecs[i], i);

    // Decimal subtract 10-01 with a start pulse arriving while busy.
    a = 8'h10; b = 8'hFE; cin = 1'b1; op = 3'd0; dec = 1'b1; sub = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    chk("dsa_c1_hold", 0, d_hold, 8'h0F);
    chk("dsa_c1_busy", 0, {6'd0, d_busy, d_h}, 8'b10);
    a = 8'h22; b = 8'h33; dec = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dsa_hold",  0, d_hold, 8'h09);
    chk("dsa_flags", 0, {5'd0, d_c, d_valid, d_busy}, 8'b110);
    @(posedge clk); #1;
    chk("drop_valid", 0, {6'd0, d_valid, d_busy}, 8'd0);
    chk("drop_hold",  0, d_hold, 8'h09);

    // Reset while in ADJUST aborts without a valid pulse.
    a = 8'h19; b = 8'h28; cin = 1'b0; dec = 1'b1; sub = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("pre_rst_busy", 0, {7'd0, d_busy}, 8'd1);
    rst_n = 1'b0; #1;
    chk("abort_hold",  0, d_hold, 8'h00);
    chk("abort_flags", 0, {3'd0, d_c, d_v, d_h, d_valid, d_busy}, 8'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_novalid", 0, {6'd0, d_valid, d_busy}, 8'd0);
    chk("abort_hold2",   0, d_hold, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
